// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: word width, register offsets,
// FSM states and the default address map.
package irq_ctrl_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] DEV0ADDR_BEGIN = 32'h0000_7F00;
  localparam logic [31:0] DEV1ADDR_BEGIN = 32'h0000_7F10;
  localparam logic [31:0] IRQC_BASE_ADDR = 32'h0000_7F20;

  // Word index within the slot, i.e. addr[4:2]
  localparam logic [2:0] IRQC_MASK  = 3'd0;
  localparam logic [2:0] IRQC_PEND  = 3'd1;
  localparam logic [2:0] IRQC_MODE  = 3'd2;
  localparam logic [2:0] IRQC_INSRV = 3'd3;
  localparam logic [2:0] IRQC_CUR   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqc_state_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder for irq_ctrl arbitration.
// Module name irq_prio_enc.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [2:0]   index,
  output logic         valid
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding CP0 HWInt.
// Define IRQC_EDGE_EN to build the MODE register and edge sources.
import irq_ctrl_pkg::*;

module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = IRQC_BASE_ADDR,
  parameter int          N_SRC     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src,
  input  logic [WORD_W-1:0] addr,
  input  logic              we,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd,
  input  logic              int_ack,
  input  logic              eret,
  output logic [5:0]        HWInt,
  output logic              busy
);

  irqc_state_e state_q, state_d;

  logic [N_SRC-1:0] mask_q, pend_q, pend_d;
  logic [N_SRC-1:0] insrv_q, req, cur_oh;
  logic [2:0]       cur_id, win_id;
  logic             win_vld, latch, take, done;
  logic             hit, wr_mask;
  logic [2:0]       sel;

  assign hit     = addr[31:5] == BASE_ADDR[31:5];
  assign sel     = addr[4:2];
  assign wr_mask = we & hit & (sel == IRQC_MASK);

  assign req    = pend_q & mask_q;
  assign cur_oh = {{(N_SRC-1){1'b0}}, 1'b1} << cur_id;
  assign busy   = state_q != IDLE;

  irq_prio_enc #(.N(N_SRC)) u_enc (
    .req   (req),
    .index (win_id),
    .valid (win_vld)
  );

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    take    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
          take    = 1'b1;
        end else if (!req[cur_id]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IRQC_EDGE_EN
  logic [N_SRC-1:0] mode_q, src_d, set, clr;
  logic             wr_pend, wr_mode;

  assign wr_pend = we & hit & (sel == IRQC_PEND);
  assign wr_mode = we & hit & (sel == IRQC_MODE);
  assign set     = src & ~src_d;
  assign clr     = (wr_pend ? wd[N_SRC-1:0] : '0)
                 | (take ? cur_oh : '0);

  // Edge-detected set beats any clear landing on the same edge.
  assign pend_d = (mode_q & (set | (pend_q & ~clr)))
                | (~mode_q & src);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      src_d  <= '0;
    end else begin
      if (wr_mode) mode_q <= wd[N_SRC-1:0];
      src_d <= src;
    end
  end
`else
  assign pend_d = src;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      insrv_q <= '0;
      cur_id  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (wr_mask) mask_q <= wd[N_SRC-1:0];
      if (latch) cur_id <= win_id;
      if (take) insrv_q <= cur_oh;
      else if (done) insrv_q <= '0;
    end
  end

  always_comb begin
    HWInt = '0;
    if (state_q == REQ) HWInt[N_SRC-1:0] = cur_oh;
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (sel)
        IRQC_MASK:  rd[N_SRC-1:0] = mask_q;
        IRQC_PEND:  rd[N_SRC-1:0] = pend_q;
`ifdef IRQC_EDGE_EN
        IRQC_MODE:  rd[N_SRC-1:0] = mode_q;
`endif
        IRQC_INSRV: rd[N_SRC-1:0] = insrv_q;
        IRQC_CUR:   rd[3:0] = {busy, cur_id};
        default:    rd = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wd[WORD_W-1:N_SRC], addr[1:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: spec-level model checked every
// cycle plus directed vectors with literal expectations.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src = '0;
  logic [31:0] addr = BASE;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic [5:0]  hwint;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  irq_ctrl #(.BASE_ADDR(BASE), .N_SRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .int_ack (int_ack),
    .eret    (eret),
    .HWInt   (hwint),
    .busy    (busy)
  );

  // Model: register contents plus two flags describing the request.
  logic [5:0] m_mask, m_pend, m_insrv, m_mode, m_srcd;
  int         m_cur;
  bit         m_wait, m_svc;

  always @(posedge clk) begin : model
    logic [5:0] rq, np, clr, set;
    bit         h;
    int         off;
    if (reset) begin
      m_mask = '0; m_pend = '0; m_insrv = '0;
      m_mode = '0; m_srcd = '0; m_cur = 0;
      m_wait = 0; m_svc = 0;
    end else begin
      rq  = m_pend & m_mask;
      h   = (addr & ~32'h1F) == BASE;
      off = int'(addr[4:0]);
      np  = src;
`ifdef IRQC_EDGE_EN
      clr = (we && h && off == 4) ? wd[5:0] : 6'b0;
      if (m_wait && int_ack) clr[m_cur] = 1'b1;
      set = src & ~m_srcd;
      for (int i = 0; i < 6; i++)
        if (m_mode[i]) np[i] = set[i] | (m_pend[i] & ~clr[i]);
      if (we && h && off == 8) m_mode = wd[5:0];
      m_srcd = src;
`else
      clr = '0;
      set = '0;
`endif
      if (m_svc) begin
        if (eret) begin
          m_svc = 0;
          m_insrv = '0;
        end
      end else if (m_wait) begin
        if (int_ack) begin
          m_wait = 0;
          m_svc = 1;
          m_insrv = 6'b1 << m_cur;
        end else if (!rq[m_cur]) begin
          m_wait = 0;
        end
      end else if (rq != 0) begin
        for (int i = 0; i < 6; i++)
          if (rq[i]) begin
            m_cur = i;
            break;
          end
        m_wait = 1;
      end
      if (we && h && off == 0) m_mask = wd[5:0];
      m_pend = np;
    end
  end

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if ((a & ~32'h1F) == BASE) begin
      case (a[4:2])
        3'd0: r[5:0] = m_mask;
        3'd1: r[5:0] = m_pend;
        3'd2: r[5:0] = m_mode;
        3'd3: r[5:0] = m_insrv;
        3'd4: r[3:0] = {m_wait || m_svc, 3'(m_cur)};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("hwint", 32'(hwint), m_wait ? 32'(6'b1 << m_cur) : 32'h0);
      chk("busy", 32'(busy), 32'(m_wait || m_svc));
      chk("rd", rd, m_rd(addr));
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    addr = BASE + 32'(off);
    wd = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [4:0] off,
                       input logic [31:0] exp);
    addr = BASE + 32'(off);
    #1;
    chk(name, rd, exp);
  endtask

  task automatic pulse_ack;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eret;
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    tick();
    go = 1'b1;
    reset = 1'b0;
    rdchk("rst_cur", 5'h10, 32'h0);
    rdchk("rst_mask", 5'h00, 32'h0);
    chk("rst_hw", 32'(hwint), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single source 1
    do_reset();
    wr(5'h00, 32'h3);
    src = 6'b000010;
    tick(); tick();
    chk("t1_hw", 32'(hwint), 32'h2);
    rdchk("t1_cur", 5'h10, 32'h9);
    pulse_ack();
    chk("t1_hw_ack", 32'(hwint), 32'h0);
    rdchk("t1_insrv", 5'h0C, 32'h2);
    pulse_eret();
    chk("t1_busy", 32'(busy), 32'h0);

    // Two simultaneous level sources
    src = '0;
    do_reset();
    wr(5'h00, 32'h3);
    src = 6'b000011;
    tick(); tick();
    chk("t2_hw", 32'(hwint), 32'h1);
    rdchk("t2_cur", 5'h10, 32'h8);
    pulse_ack();
    pulse_eret();
    tick();
    chk("t2_hw_again", 32'(hwint), 32'h1);
    rdchk("t2_cur_again", 5'h10, 32'h8);

    // Mask dropped while requesting
    src = '0;
    do_reset();
    wr(5'h00, 32'h3);
    src = 6'b000010;
    tick(); tick();
    chk("t3_hw", 32'(hwint), 32'h2);
    wr(5'h00, 32'h0);
    chk("t3_hw_hold", 32'(hwint), 32'h2);
    tick();
    chk("t3_hw_drop", 32'(hwint), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    pulse_ack();
    chk("t3_busy_ack", 32'(busy), 32'h0);
    rdchk("t3_insrv", 5'h0C, 32'h0);

`ifdef IRQC_EDGE_EN
    // Edge source with W1C collision
    src = '0;
    do_reset();
    wr(5'h08, 32'h1);
    src = 6'b000001;
    tick();
    src = '0;
    tick();
    rdchk("t4_pend", 5'h04, 32'h1);
    addr = BASE + 32'h4;
    wd = 32'h1;
    we = 1'b1;
    src = 6'b000001;
    tick();
    we = 1'b0;
    src = '0;
    rdchk("t4_pend_w1c", 5'h04, 32'h1);
    wr(5'h00, 32'h1);
    tick();
    chk("t4_hw", 32'(hwint), 32'h1);
    pulse_ack();
    rdchk("t4_pend_ack", 5'h04, 32'h0);
    pulse_eret();
`else
    // Level-only build: PEND tracks src, writes ignored
    src = '0;
    do_reset();
    src = 6'b000100;
    tick();
    rdchk("t4_pend", 5'h04, 32'h4);
    wr(5'h04, 32'h3F);
    rdchk("t4_pend_wr", 5'h04, 32'h4);
    wr(5'h08, 32'h1);
    rdchk("t4_mode", 5'h08, 32'h0);
`endif

    // Reset during SERVICE
    src = '0;
    do_reset();
    wr(5'h00, 32'h3);
    src = 6'b000001;
    tick(); tick();
    pulse_ack();
    chk("t5_busy", 32'(busy), 32'h1);
    rdchk("t5_insrv", 5'h0C, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_hw", 32'(hwint), 32'h0);
    rdchk("t5_insrv_rst", 5'h0C, 32'h0);
    rdchk("t5_mask_rst", 5'h00, 32'h0);
    pulse_eret();
    chk("t5_busy_eret", 32'(busy), 32'h0);

    // Unmapped offsets
    src = '0;
    do_reset();
    wr(5'h00, 32'h3);
    rdchk("t6_r14", 5'h14, 32'h0);
    rdchk("t6_r1c", 5'h1C, 32'h0);
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h1C, 32'hFFFF_FFFF);
    rdchk("t6_mask", 5'h00, 32'h3);
    rdchk("t6_mode", 5'h08, 32'h0);
    rdchk("t6_insrv", 5'h0C, 32'h0);
    addr = 32'h0000_7F00;
    #1;
    chk("t6_outside", rd, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
